rate_scheduler: RTL and testbench
=================================

Name: rate_scheduler

Overview:
- Runtime-programmable rate controller for the waveform generator's clock-division path.
- Owns the divide counter and the active divisor.
- Accepts divisor change requests from the control logic (switch and button decode) and applies each one only at a period boundary, so the output never has a runt or stretched pulse.
- Drives a 50%-nominal square output and a one-cycle period-start tick that downstream waveform logic (counters, LUT address steppers) uses as a clock enable.

Parameters:
- CNT_W, 28, width of the divisor and the counter.
- DEFAULT_DIV, 28'd10000, divisor loaded at reset.
- MIN_DIV, 28'd2, smallest legal divisor; requests below it are clamped up to it.

Ports:
- clock_in  input  1  system clock, 100 MHz board clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level; high = run, low = stop.
- div_req  input  CNT_W  requested divisor.
- div_load  input  1  one-cycle strobe; captures div_req.
- clock_out  output  1  divided square wave.
- tick  output  1  one-cycle pulse on the first cycle of every period.
- div_active  output  CNT_W  divisor currently in use.
- pending  output  1  high while a captured request awaits its boundary.
- running  output  1  high in RUN or RUN_PEND.

Behaviour:
- Reset (async, high), immediate:
  - state=STOPPED, counter=0, div_active=DEFAULT_DIV, div_pend=0, pending=0.
  - clock_out=0, tick=0, running=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Phase definition: counter p runs 0..D-1 with D=div_active.
  - In RUN/RUN_PEND, the cycle holding phase p has clock_out=(p < D>>1) and tick=(p==0).
  - Odd D: high for floor(D/2) cycles, low for ceil(D/2) cycles.
- States:
  - STOPPED: counter=0, clock_out=0, tick=0. On enable=1, go to RUN (or RUN_PEND if a request is already captured). Phase 0 appears on the cycle after the edge that samples enable=1, i.e. one cycle of latency.
  - RUN: counter increments by 1 per cycle. At p==D-1 it wraps to 0.
  - RUN_PEND: same counting as RUN. At the wrap edge, div_active<=div_pend, pending<=0, and the state returns to RUN. The new D governs phase 0 of the new period, including its clock_out level and the phase-0 tick.
  - Any running state with enable=0: at the next edge go to STOPPED. The current period is abandoned, counter goes to 0, clock_out to 0, and no tick is issued.
- Request capture:
  - On div_load=1, div_pend <= max(div_req, MIN_DIV) and pending <= 1.
  - In STOPPED, a load is applied directly: div_active updates at that edge, pending stays 0, and the state does not change.
  - In RUN/RUN_PEND, a load goes to RUN_PEND. A later load before the boundary overwrites div_pend (last writer wins).
  - A load on the same cycle as the wrap (p==D-1) is captured but not applied at that wrap. The old div_pend, if any, is applied, and the new request waits for the next boundary, so pending stays 1.
  - A load equal to div_active is still treated as a request (pending goes high, then clears at the boundary).
- Arithmetic:
  - Comparisons are unsigned at CNT_W.
  - D>>1 is computed from the registered div_active.
  - The counter never exceeds D-1.
  - div_req=0 or 1 becomes MIN_DIV.
- Reset mid-period or with a request pending: everything clears to reset values and the pending request is discarded.

Test Plan:
- Reset, then enable=1 with no load, DEFAULT_DIV overridden to 10 -> first tick one cycle after enable, clock_out high 5 cycles and low 5, tick every 10 cycles, running=1.
- Running at D=10, pulse div_load with div_req=4 at phase 3 -> pending=1 at phases 4..9, current period completes at 10 cycles, then periods of 4 (high 2, low 2), div_active=4 at the wrap, pending=0.
- Running at D=10, loads of 6 then 8 at phases 2 and 5 -> one boundary switch directly to 8; 6 is never used.
- div_load with div_req=8 exactly at phase 9 of D=10 -> next period is still 10 long with pending=1, then it switches to 8.
- STOPPED, div_load with div_req=0 -> div_active=2, pending=0. Enable -> clock_out toggles every cycle and tick appears every 2 cycles. With div_req=7: high 3, low 4.
- Running at D=10 with a request pending: drop enable at phase 4 -> next cycle clock_out=0, tick=0, counter=0, state STOPPED, request still pending. Re-enable applies it at the first boundary. Asserting reset at phase 6 instead -> outputs clear immediately and div_active=DEFAULT_DIV.

Source files
------------

// File: rtl/rate_if.sv
// Control/observation bundle for the rate scheduler.
// The control logic drives requests; waveform logic consumes tick/clock_out.
interface rate_if #(
  parameter int CNT_W = 28
);
  logic             enable;
  logic [CNT_W-1:0] div_req;
  logic             div_load;
  logic             clock_out;
  logic             tick;
  logic [CNT_W-1:0] div_active;
  logic             pending;
  logic             running;

  modport master (
    output enable, div_req, div_load,
    input  clock_out, tick, div_active,
    input  pending, running
  );

  modport slave (
    input  enable, div_req, div_load,
    output clock_out, tick, div_active,
    output pending, running
  );
endinterface

// File: rtl/rate_scheduler.sv
// Programmable clock divider; divisor changes only land on a
// period boundary so clock_out never shows a runt or stretched pulse.
module rate_scheduler #(
  parameter int             CNT_W       = 28,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(10000),
  parameter logic [CNT_W-1:0] MIN_DIV     = CNT_W'(2)
) (
  input  logic clock_in,
  input  logic reset,
  rate_if.slave bus
);

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] req_clamp;
  logic             wrap;

  assign req_clamp = (bus.div_req < MIN_DIV) ? MIN_DIV : bus.div_req;
  assign wrap      = cnt_q >= (div_active_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    div_pend_d   = div_pend_q;
    pending_d    = pending_q;
    clk_out_d    = 1'b0;
    tick_d       = 1'b0;
    case (state_q)
      STOPPED: begin
        cnt_d = '0;
        // Nothing is running, so a new divisor can take effect at once.
        if (bus.div_load) begin
          div_active_d = req_clamp;
          div_pend_d   = req_clamp;
          pending_d    = 1'b0;
        end
        if (bus.enable)
          state_d = pending_d ? RUN_PEND : RUN;
      end
      RUN, RUN_PEND: begin
        if (!bus.enable) begin
          state_d = STOPPED;
          cnt_d   = '0;
        end else if (wrap) begin
          cnt_d = '0;
          if (state_q == RUN_PEND) begin
            div_active_d = div_pend_q;
            pending_d    = 1'b0;
            state_d      = RUN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A load on the wrap edge waits for the following boundary.
        if (bus.div_load) begin
          div_pend_d = req_clamp;
          pending_d  = 1'b1;
          if (bus.enable)
            state_d = RUN_PEND;
        end
      end
      default: begin
        state_d = STOPPED;
        cnt_d   = '0;
      end
    endcase
    if (state_d != STOPPED) begin
      tick_d    = (cnt_d == '0);
      clk_out_d = cnt_d < (div_active_d >> 1);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= STOPPED;
      cnt_q        <= '0;
      div_active_q <= DEFAULT_DIV;
      div_pend_q   <= '0;
      pending_q    <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
      pending_q    <= pending_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.clock_out  = clk_out_q;
  assign bus.tick       = tick_q;
  assign bus.div_active = div_active_q;
  assign bus.pending    = pending_q;
  assign bus.running    = (state_q != STOPPED);

endmodule

// File: tb/tb_rate_scheduler.sv
// Scoreboard bench for rate_scheduler with DEFAULT_DIV set to 10.
// Expected per-cycle outputs are queued from period shapes, then popped.
module tb_rate_scheduler;
  localparam int CNT_W = 28;

  typedef struct packed {
    logic             tick;
    logic             co;
    logic             pend;
    logic             run;
    logic [CNT_W-1:0] div;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  rate_if #(.CNT_W(CNT_W)) bus ();

  rate_scheduler #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(CNT_W'(10)),
    .MIN_DIV    (CNT_W'(2))
  ) dut (
    .clock_in(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t rst_exp();
    exp_t e;
    e = '{tick: 1'b0, co: 1'b0, pend: 1'b0, run: 1'b0, div: CNT_W'(10)};
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g = '{tick: bus.tick, co: bus.clock_out, pend: bus.pending,
          run: bus.running, div: bus.div_active};
    return g;
  endfunction

  task automatic push_span(input int d, input int from, input int to,
                           input logic pend);
    exp_t e;
    for (int p = from; p < to; p++) begin
      e = '{tick: (p == 0), co: (p < d / 2), pend: pend,
            run: 1'b1, div: CNT_W'(d)};
      q.push_back(e);
    end
  endtask

  task automatic push_stop(input logic pend, input int d);
    exp_t e;
    e = '{tick: 1'b0, co: 1'b0, pend: pend, run: 1'b0, div: CNT_W'(d)};
    q.push_back(e);
  endtask

  task automatic next_cycle(output exp_t got, output exp_t e,
                            output bit have);
    @(posedge clk);
    #1;
    got  = sample();
    have = (q.size() != 0);
    e    = have ? q.pop_front() : '0;
  endtask

  task automatic do_reset();
    bus.enable   = 1'b0;
    bus.div_load = 1'b0;
    bus.div_req  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    exp_t got;
    do_reset();
    got = sample();
    checks++;
    if (got !== rst_exp()) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", got, rst_exp());
    end
    bus.enable = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    got = sample();
    checks++;
    if (got !== rst_exp()) begin
      fails++;
      $display("FAIL reset_async: got %h want %h", got, rst_exp());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.enable = 1'b0;
  endtask

  task automatic test_basic();
    exp_t got, e;
    bit have;
    do_reset();
    bus.enable = 1'b1;
    repeat (3) push_span(10, 0, 10, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL basic cyc %0d: got %h want %h", k, got, e);
      end
    end
  endtask

  task automatic test_switch();
    exp_t got, e;
    bit have;
    do_reset();
    bus.enable = 1'b1;
    push_span(10, 0, 4, 1'b0);
    push_span(10, 4, 10, 1'b1);
    repeat (3) push_span(4, 0, 4, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL switch cyc %0d: got %h want %h", k, got, e);
      end
      bus.div_load = (k == 4);
      bus.div_req  = CNT_W'(4);
    end
  endtask

  task automatic test_last_writer();
    exp_t got, e;
    bit have;
    do_reset();
    bus.enable = 1'b1;
    push_span(10, 0, 3, 1'b0);
    push_span(10, 3, 10, 1'b1);
    repeat (2) push_span(8, 0, 8, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL last_writer cyc %0d: got %h want %h", k, got, e);
      end
      bus.div_load = (k == 3) || (k == 6);
      bus.div_req  = (k == 3) ? CNT_W'(6) : CNT_W'(8);
    end
  endtask

  task automatic test_wrap_load();
    exp_t got, e;
    bit have;
    do_reset();
    bus.enable = 1'b1;
    push_span(10, 0, 10, 1'b0);
    push_span(10, 0, 10, 1'b1);
    repeat (2) push_span(8, 0, 8, 1'b0);
    for (int k = 1; k <= 36; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL wrap_load cyc %0d: got %h want %h", k, got, e);
      end
      bus.div_load = (k == 10);
      bus.div_req  = CNT_W'(8);
    end
  endtask

  task automatic test_min_div();
    exp_t got, e;
    bit have;
    do_reset();
    bus.div_load = 1'b1;
    bus.div_req  = '0;
    push_stop(1'b0, 2);
    repeat (3) push_span(2, 0, 2, 1'b0);
    push_stop(1'b0, 2);
    push_stop(1'b0, 7);
    repeat (2) push_span(7, 0, 7, 1'b0);
    for (int k = 1; k <= 23; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL min_div cyc %0d: got %h want %h", k, got, e);
      end
      bus.div_load = (k == 8);
      bus.div_req  = CNT_W'(7);
      bus.enable   = (k >= 1 && k < 7) || (k >= 9);
    end
  endtask

  task automatic test_stop();
    exp_t got, e;
    bit have;
    do_reset();
    bus.enable = 1'b1;
    push_span(10, 0, 3, 1'b0);
    push_span(10, 3, 5, 1'b1);
    push_stop(1'b1, 10);
    push_stop(1'b1, 10);
    push_span(10, 0, 10, 1'b1);
    repeat (2) push_span(4, 0, 4, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL stop cyc %0d: got %h want %h", k, got, e);
      end
      bus.div_load = (k == 3);
      bus.div_req  = CNT_W'(4);
      bus.enable   = !(k == 5 || k == 6);
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, e;
    bit have;
    do_reset();
    bus.enable = 1'b1;
    push_span(10, 0, 3, 1'b0);
    push_span(10, 3, 7, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", k, got, e);
      end
      bus.div_load = (k == 3);
      bus.div_req  = CNT_W'(4);
    end
    #2;
    rst = 1'b1;
    #1;
    got = sample();
    checks++;
    if (got !== rst_exp()) begin
      fails++;
      $display("FAIL reset_mid_async: got %h want %h", got, rst_exp());
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    push_span(10, 0, 10, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      next_cycle(got, e, have);
      checks++;
      if (!have || got !== e) begin
        fails++;
        $display("FAIL reset_discard cyc %0d: got %h want %h", k, got, e);
      end
    end
  endtask

  initial begin
    bus.enable   = 1'b0;
    bus.div_load = 1'b0;
    bus.div_req  = '0;
    test_reset();
    test_basic();
    test_switch();
    test_last_writer();
    test_wrap_load();
    test_min_div();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
